rob_wb_arbiter: RTL and testbench
=================================

// Module: rob_wb_arbiter
// PURPOSE
//  Shares the ROB's four completion (busy-clear) ports between NREQ functional-unit
//  writeback requesters. Each requester presents a ROB tag {row, bank} plus branch mask;
//  the block buffers one entry per requester and round-robin arbitrates per ROB bank.
//  It drops entries on branch kill and drives the rob i_rst_busy0..3 inputs from registers.
// PARAMETERS
//  NREQ        6  number of writeback requesters (2..16)
//  WIDTH_BANK  3  ROB row-index width (rows per bank = 2**WIDTH_BANK)
//  WIDTH_BRM   4  branch-mask width
// PORTS
//  i_clk          in   1                 clock, all state on posedge
//  i_rst_n        in   1                 async active-low reset
//  i_req_vld      in   NREQ              requester r has a completion this cycle
//  i_req_tag      in   NREQ*(WIDTH_BANK+2) per-req {row[WIDTH_BANK-1:0], bank[1:0]}, req r at slice r
//  i_req_brm      in   NREQ*WIDTH_BRM    per-req branch mask of the completing uop
//  o_req_rdy      out  NREQ              req r's entry accepted at this edge when vld&rdy
//  i_kill         in   1+WIDTH_BRM       {en, mask}: squash all entries with (brm & mask)!=0
//  o_rst_busy0..3 out  1+WIDTH_BANK+2    each {en, row, bank}; port k always has bank field == k
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): all hold slots invalid, o_rst_busyK = {1'b0, 0, k[1:0]},
//    RR pointers = 0, o_req_rdy = all ones. Reset mid-operation discards held entries.
//  - Hold slot per requester: {v, row, bank, brm}. o_req_rdy[r] = !v[r] | grant[r]
//    (combinational from state + grant only; never from i_req_vld -> no comb loop).
//  - Accept: vld&rdy at edge loads slot; if same-cycle i_kill.en and (brm & mask)!=0, the
//    request is consumed (rdy asserted) but slot stays invalid.
//  - Kill: held slot with i_kill.en and (brm & mask)!=0 is not eligible this cycle and is
//    cleared at the edge. Output registers are not killed (ROB ignores squashed rows).
//  - Arbitration, per bank k in parallel: candidates = valid, unkilled slots with bank==k.
//    Winner = first candidate at or after rr[k] (index wraps NREQ-1 -> 0). At most one
//    grant per bank per cycle; up to 4 grants/cycle total across banks.
//  - rr[k] <= winner+1 (mod NREQ) when bank k grants; unchanged otherwise. A continuously
//    requesting slot waits at most NREQ-1 grants of its bank (starvation-free).
//  - Outputs registered: o_rst_busyK <= {grant_any_k, row_of_winner, k}; when no grant,
//    en=0 and row=0. Latency: req accepted at edge E -> slot valid cycle E+1 -> granted ->
//    o_rst_busyK en visible in cycle after edge E+1 (min 2 edges from request cycle).
//  - Granted slot cleared at edge unless re-loaded the same edge (back-to-back: a
//    requester can sustain 1 completion/cycle while it wins every cycle).
//  - Width rules: rr pointers $clog2(NREQ) bits; wrap handled by explicit compare, not
//    power-of-two overflow. Tag bank field is always taken from i_req_tag, never inferred.
//  - Two requests for the same {row,bank}: illegal (ROB tags are unique); no check required,
//    both are forwarded in grant order.
// STRUCTURE
//  - rob_pkg: ROB_BANKS=4, BANK_SEL_W=2, typedef wb_tag_t {row, bank}, typedef rst_busy_t
//    {en, row, bank}; shared with rob and dispatch.
//  - Sub-module rr_arbiter #(N) : req[N], ptr -> one-hot gnt[N], any; instantiated 4x
//    (one per bank). Hold slots, kill filtering and output regs live in the top.
// TESTING
//  1 Reset: hold i_rst_n=0 with vld all 1 -> all o_rst_busyK en=0, bank=k, rdy all 1.
//  2 Bank spread: req0..3 vld at once, tags {row=5,bank=0..3} -> two edges later all four
//    ports en=1 row=5 in the same cycle; rdy stays 1 throughout.
//  3 Contention: req0,req2,req4 all bank 1 rows 1,2,3 held continuously -> o_rst_busy1
//    row sequence 1,2,3 on consecutive cycles (rr from 0), then re-loaded req0 served 4th.
//  4 Fairness: req5 refills bank 2 every cycle, req1 also bank 2 -> grants alternate
//    1,5,1,5; req1 never waits more than NREQ-1 cycles.
//  5 Kill: slots req0 brm=4'b0001, req1 brm=4'b0010 both bank 3, i_kill={1,4'b0001}
//    -> req0 dropped, only req1's row appears on port 3; new req with brm 0001 same
//    cycle: rdy=1, never appears.
//  6 Async reset mid-stream with 4 slots valid -> outputs en=0 immediately, no held entry
//    appears after reset release.

Source files
------------

// File: rtl/rob_pkg.sv
// ROB-wide constants and tag types shared by the ROB, dispatch and the writeback arbiter.
package rob_pkg;
    localparam int ROB_BANKS  = 4;
    localparam int BANK_SEL_W = 2;
    localparam int ROB_ROW_W  = 3;

    typedef struct packed {
        logic [ROB_ROW_W-1:0]  row;
        logic [BANK_SEL_W-1:0] bank;
    } wb_tag_t;

    typedef struct packed {
        logic                  en;
        logic [ROB_ROW_W-1:0]  row;
        logic [BANK_SEL_W-1:0] bank;
    } rst_busy_t;

    function automatic logic [BANK_SEL_W-1:0] bank_id(input int k);
        return k[BANK_SEL_W-1:0];
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, index wraps N-1 -> 0.
module rr_arbiter #(
    parameter int N  = 6,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);
    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Walk the N positions starting at ptr, wrapping by explicit compare against N
    always_comb begin
        gnt     = '0;
        sum_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum_s = {1'b0, ptr} + (PW+1)'(i);
            if (sum_s >= (PW+1)'(N)) begin
                idx_s = PW'(sum_s - (PW+1)'(N));
            end else begin
                idx_s = PW'(sum_s);
            end
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any = found_s;
    end
endmodule

// File: rtl/rob_wb_arbiter.sv
// Buffers one writeback completion per requester and arbitrates them onto the four
// per-bank ROB busy-clear ports, dropping entries squashed by a branch kill.
module rob_wb_arbiter
    import rob_pkg::*;
#(
    parameter int NREQ       = 6,
    parameter int WIDTH_BANK = 3,
    parameter int WIDTH_BRM  = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NREQ-1:0]                  i_req_vld,
    input  logic [NREQ*(WIDTH_BANK+2)-1:0]   i_req_tag,
    input  logic [NREQ*WIDTH_BRM-1:0]        i_req_brm,
    output logic [NREQ-1:0]                  o_req_rdy,
    input  logic [WIDTH_BRM:0]               i_kill,
    output logic [WIDTH_BANK+2:0]            o_rst_busy0,
    output logic [WIDTH_BANK+2:0]            o_rst_busy1,
    output logic [WIDTH_BANK+2:0]            o_rst_busy2,
    output logic [WIDTH_BANK+2:0]            o_rst_busy3
);
    localparam int TAG_W = WIDTH_BANK + BANK_SEL_W;
    localparam int OUT_W = 1 + TAG_W;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       slot_v_r;
    logic [WIDTH_BANK-1:0] slot_row_r  [NREQ];
    logic [BANK_SEL_W-1:0] slot_bank_r [NREQ];
    logic [WIDTH_BRM-1:0]  slot_brm_r  [NREQ];
    logic [PTR_W-1:0]      rr_r        [ROB_BANKS];
    logic [OUT_W-1:0]      busy_r      [ROB_BANKS];

    logic [NREQ-1:0]       slot_kill_s;
    logic [NREQ-1:0]       in_kill_s;
    logic [NREQ-1:0]       grant_s;
    logic [NREQ-1:0]       cand_s      [ROB_BANKS];
    logic [NREQ-1:0]       gnt_s       [ROB_BANKS];
    logic [ROB_BANKS-1:0]  any_s;
    logic [PTR_W-1:0]      win_idx_s   [ROB_BANKS];
    logic [WIDTH_BANK-1:0] win_row_s   [ROB_BANKS];

    // Kill hits for held slots and for incoming requests
    always_comb begin
        slot_kill_s = '0;
        in_kill_s   = '0;
        for (int r = 0; r < NREQ; r++) begin
            slot_kill_s[r] = i_kill[WIDTH_BRM] & (|(slot_brm_r[r] & i_kill[WIDTH_BRM-1:0]));
            in_kill_s[r]   = i_kill[WIDTH_BRM] &
                             (|(i_req_brm[r*WIDTH_BRM +: WIDTH_BRM] & i_kill[WIDTH_BRM-1:0]));
        end
    end

    // Per-bank candidate sets: valid, not being killed, bank matches
    always_comb begin
        for (int k = 0; k < ROB_BANKS; k++) begin
            cand_s[k] = '0;
            for (int r = 0; r < NREQ; r++) begin
                cand_s[k][r] = slot_v_r[r] & ~slot_kill_s[r] & (slot_bank_r[r] == bank_id(k));
            end
        end
    end

    for (genvar k = 0; k < ROB_BANKS; k++) begin : g_bank
        rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_rr (
            .req (cand_s[k]),
            .ptr (rr_r[k]),
            .gnt (gnt_s[k]),
            .any (any_s[k])
        );
    end

    // One-hot grants to winner index/row; row stays zero when the bank is idle
    always_comb begin
        grant_s = '0;
        for (int k = 0; k < ROB_BANKS; k++) begin
            win_idx_s[k] = '0;
            win_row_s[k] = '0;
            for (int r = 0; r < NREQ; r++) begin
                win_idx_s[k] = win_idx_s[k] | ({PTR_W{gnt_s[k][r]}} & PTR_W'(r));
                win_row_s[k] = win_row_s[k] | ({WIDTH_BANK{gnt_s[k][r]}} & slot_row_r[r]);
            end
            grant_s = grant_s | gnt_s[k];
        end
    end

    // Depends only on state and grants, so no path from i_req_vld
    assign o_req_rdy = ~slot_v_r | grant_s;

    // Hold slots: load on handshake (invalid if killed on arrival), clear on grant or kill
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_v_r <= '0;
            for (int r = 0; r < NREQ; r++) begin
                slot_row_r[r]  <= '0;
                slot_bank_r[r] <= '0;
                slot_brm_r[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (i_req_vld[r] && o_req_rdy[r]) begin
                    slot_v_r[r]    <= ~in_kill_s[r];
                    slot_row_r[r]  <= i_req_tag[r*TAG_W+BANK_SEL_W +: WIDTH_BANK];
                    slot_bank_r[r] <= i_req_tag[r*TAG_W +: BANK_SEL_W];
                    slot_brm_r[r]  <= i_req_brm[r*WIDTH_BRM +: WIDTH_BRM];
                end else if (grant_s[r] || slot_kill_s[r]) begin
                    slot_v_r[r] <= 1'b0;
                end else begin
                    slot_v_r[r] <= slot_v_r[r];
                end
            end
        end
    end

    // Registered busy-clear ports and round-robin pointers (advance past winner only)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < ROB_BANKS; k++) begin
                rr_r[k]   <= '0;
                busy_r[k] <= {1'b0, {WIDTH_BANK{1'b0}}, bank_id(k)};
            end
        end else begin
            for (int k = 0; k < ROB_BANKS; k++) begin
                busy_r[k] <= {any_s[k], win_row_s[k], bank_id(k)};
                if (any_s[k]) begin
                    rr_r[k] <= (win_idx_s[k] == PTR_W'(NREQ-1)) ? '0 : win_idx_s[k] + PTR_W'(1);
                end else begin
                    rr_r[k] <= rr_r[k];
                end
            end
        end
    end

    assign o_rst_busy0 = busy_r[0];
    assign o_rst_busy1 = busy_r[1];
    assign o_rst_busy2 = busy_r[2];
    assign o_rst_busy3 = busy_r[3];
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Self-checking bench for rob_wb_arbiter: vector table, directed corner sequences and
// random traffic against a slot/queue-level reference model.
module tb_rob_wb_arbiter;
    localparam int NREQ = 6;
    localparam int WB   = 3;
    localparam int WBRM = 4;
    localparam int TW   = WB + 2;
    localparam int OW   = TW + 1;

    typedef struct packed {
        logic [NREQ-1:0]        vld;
        logic [NREQ*TW-1:0]     tag;
        logic [NREQ*WBRM-1:0]   brm;
        logic [WBRM:0]          kill;
        logic [NREQ-1:0]        rdy;
        logic [3:0][OW-1:0]     o;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        vld;
    logic [NREQ-1:0]        rdy;
    logic [NREQ*TW-1:0]     tag;
    logic [NREQ*WBRM-1:0]   brm;
    logic [WBRM:0]          kill;
    logic [OW-1:0]          ob [4];

    int n_chk  = 0;
    int n_fail = 0;
    int m_v[NREQ], m_row[NREQ], m_bank[NREQ], m_brm[NREQ];
    int m_rr[4], m_en[4], m_orow[4];

    rob_wb_arbiter #(.NREQ(NREQ), .WIDTH_BANK(WB), .WIDTH_BRM(WBRM)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_vld   (vld),
        .i_req_tag   (tag),
        .i_req_brm   (brm),
        .o_req_rdy   (rdy),
        .i_kill      (kill),
        .o_rst_busy0 (ob[0]),
        .o_rst_busy1 (ob[1]),
        .o_rst_busy2 (ob[2]),
        .o_rst_busy3 (ob[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] ev(input int k, input int en, input int row);
        return OW'((en << TW) | (row << 2) | k);
    endfunction

    function automatic logic [NREQ*TW-1:0] pk_tag(input int r, input int row, input int bank);
        logic [NREQ*TW-1:0] v;
        v = (NREQ*TW)'((row << 2) | bank);
        return v << (r*TW);
    endfunction

    function automatic logic [NREQ*WBRM-1:0] pk_brm(input int r, input int b);
        logic [NREQ*WBRM-1:0] v;
        v = (NREQ*WBRM)'(b);
        return v << (r*WBRM);
    endfunction

    function automatic logic [3:0][OW-1:0] all_o(input int en, input int row);
        return {ev(3, en, row), ev(2, en, row), ev(1, en, row), ev(0, en, row)};
    endfunction

    task automatic idle();
        vld = '0; tag = '0; brm = '0; kill = '0;
    endtask

    task automatic set_req(input int r, input int row, input int bank, input int b);
        vld[r] = 1'b1;
        tag[r*TW +: TW] = TW'((row << 2) | bank);
        brm[r*WBRM +: WBRM] = WBRM'(b);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREQ; r++) begin
            m_v[r] = 0; m_row[r] = 0; m_bank[r] = 0; m_brm[r] = 0;
        end
        for (int k = 0; k < 4; k++) begin
            m_rr[k] = 0; m_en[k] = 0; m_orow[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check rdy against the model before the edge, outputs after it.
    task automatic step(output logic [NREQ-1:0] rs);
        int win[4];
        bit kl[NREQ];
        bit gr[NREQ];
        logic [NREQ-1:0] er;
        int kmask, r;
        @(negedge clk);
        kmask = kill[WBRM] ? int'(kill[WBRM-1:0]) : 0;
        for (int q = 0; q < NREQ; q++) begin
            kl[q] = (m_v[q] != 0) && ((m_brm[q] & kmask) != 0);
            gr[q] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            win[k] = -1;
            for (int i = 0; i < NREQ; i++) begin
                r = (m_rr[k] + i) % NREQ;
                if (win[k] < 0 && m_v[r] != 0 && !kl[r] && m_bank[r] == k) win[k] = r;
            end
            if (win[k] >= 0) begin
                gr[win[k]] = 1'b1;
                m_en[k] = 1;
                m_orow[k] = m_row[win[k]];
                m_rr[k] = (win[k] + 1) % NREQ;
            end else begin
                m_en[k] = 0;
                m_orow[k] = 0;
            end
        end
        for (int q = 0; q < NREQ; q++) er[q] = (m_v[q] == 0) || gr[q];
        chk("rdy", 32'(rdy), 32'(er));
        rs = rdy;
        for (int q = 0; q < NREQ; q++) begin
            if (vld[q] && er[q]) begin
                m_brm[q]  = int'(brm[q*WBRM +: WBRM]);
                m_v[q]    = ((m_brm[q] & kmask) == 0) ? 1 : 0;
                m_row[q]  = int'(tag[q*TW+2 +: WB]);
                m_bank[q] = int'(tag[q*TW +: 2]);
            end else if (gr[q] || kl[q]) begin
                m_v[q] = 0;
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) chk($sformatf("port%0d", k), 32'(ob[k]), 32'(ev(k, m_en[k], m_orow[k])));
    endtask

    initial begin
        vec_t tbl[7];
        int seq3[4];
        logic [NREQ-1:0] rs;

        seq3 = '{1, 2, 3, 1};

        // Reset with all requesters valid
        rst_n = 1'b0;
        vld = '1; tag = '1; brm = '0; kill = '0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_port%0d", k), 32'(ob[k]), 32'(ev(k, 0, 0)));
        chk("reset_rdy", 32'(rdy), 32'(6'h3F));
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;

        // Vector table: bank spread then kill scenario
        tbl[0] = '{vld: 6'b001111, tag: pk_tag(0,5,0) | pk_tag(1,5,1) | pk_tag(2,5,2) | pk_tag(3,5,3),
                   brm: '0, kill: '0, rdy: 6'h3F, o: all_o(0, 0)};
        tbl[1] = '{vld: '0, tag: '0, brm: '0, kill: '0, rdy: 6'h3F, o: all_o(1, 5)};
        tbl[2] = '{vld: '0, tag: '0, brm: '0, kill: '0, rdy: 6'h3F, o: all_o(0, 0)};
        tbl[3] = '{vld: 6'b000011, tag: pk_tag(0,2,3) | pk_tag(1,4,3), brm: pk_brm(0,1) | pk_brm(1,2),
                   kill: '0, rdy: 6'h3F, o: all_o(0, 0)};
        tbl[4] = '{vld: 6'b000100, tag: pk_tag(2,6,3), brm: pk_brm(2,1), kill: 5'b10001,
                   rdy: 6'b111110, o: {ev(3,1,4), ev(2,0,0), ev(1,0,0), ev(0,0,0)}};
        tbl[5] = '{vld: '0, tag: '0, brm: '0, kill: '0, rdy: 6'h3F, o: all_o(0, 0)};
        tbl[6] = '{vld: '0, tag: '0, brm: '0, kill: '0, rdy: 6'h3F, o: all_o(0, 0)};
        for (int i = 0; i < 7; i++) begin
            vld = tbl[i].vld; tag = tbl[i].tag; brm = tbl[i].brm; kill = tbl[i].kill;
            step(rs);
            chk($sformatf("tbl%0d_rdy", i), 32'(rs), 32'(tbl[i].rdy));
            for (int k = 0; k < 4; k++)
                chk($sformatf("tbl%0d_port%0d", i, k), 32'(ob[k]), 32'(tbl[i].o[k]));
        end

        // Contention on bank 1, requests held continuously
        do_reset();
        set_req(0, 1, 1, 0); set_req(2, 2, 1, 0); set_req(4, 3, 1, 0);
        step(rs);
        for (int c = 0; c < 4; c++) begin
            step(rs);
            if (c == 0) chk("contention_rdy", 32'(rs), 32'(6'b101011));
            chk($sformatf("contention_%0d", c), 32'(ob[1]), 32'(ev(1, 1, seq3[c])));
        end

        // Fairness: req5 refills bank 2 every cycle alongside req1
        do_reset();
        set_req(1, 1, 2, 0); set_req(5, 5, 2, 0);
        step(rs);
        for (int c = 0; c < 6; c++) begin
            step(rs);
            chk($sformatf("fair_%0d", c), 32'(ob[2]), 32'(ev(2, 1, (c % 2 == 0) ? 1 : 5)));
        end

        // Async reset with four slots held on bank 0
        do_reset();
        for (int r = 0; r < 4; r++) set_req(r, r + 1, 0, 0);
        step(rs);
        idle();
        step(rs);
        chk("pre_rst_port0", 32'(ob[0]), 32'(ev(0, 1, 1)));
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("async_rst_port%0d", k), 32'(ob[k]), 32'(ev(k, 0, 0)));
        chk("async_rst_rdy", 32'(rdy), 32'(6'h3F));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(rs);
            chk($sformatf("post_rst_%0d", c), 32'(ob[0]), 32'(ev(0, 0, 0)));
        end

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            vld = NREQ'($urandom);
            for (int r = 0; r < NREQ; r++) begin
                tag[r*TW +: TW]     = TW'($urandom);
                brm[r*WBRM +: WBRM] = WBRM'($urandom);
            end
            kill = ($urandom_range(0, 3) == 0) ? {1'b1, WBRM'($urandom)} : '0;
            step(rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
